// File: rtl/q_max_finder.sv
// ---------------------------------------------------------------------------
// q_max_finder
//
// Scans the Q-table row of one board state and returns the largest legal
// Q value (max_q) together with the action that holds it (best_action).
// max_q feeds the updater's gamma*max_Q term; best_action feeds the move
// selector. The Q-table RAM has a synchronous read with 1-cycle latency.
//
// Sequence: IDLE -> SCAN (N_ACTIONS cycles) -> DRAIN (1) -> DONE (1) -> IDLE.
// The scan always walks every action, so latency from start to done is
// fixed regardless of legal_mask. Illegal cells never issue a RAM read.
//
// Handshake: start is sampled only in IDLE; a start seen in any other state
// is dropped, not queued. busy is high from the cycle after start is
// accepted through the done cycle. done is a one-cycle pulse; max_q,
// best_action and no_legal are valid from that cycle and hold until the
// next done or reset.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-high reset
//   start        in   request a scan (sampled in IDLE only)
//   state_idx    in   board state to scan, captured with start
//   legal_mask   in   bit k=1 -> action k legal, captured with start
//   busy         out  scan in progress
//   done         out  one-cycle completion pulse
//   q_rd_en      out  Q-table read strobe
//   q_rd_state   out  Q-table read row (captured state_idx)
//   q_rd_action  out  Q-table read column (action counter)
//   q_rd_data    in   Q-table data, valid the cycle after q_rd_en
//   max_q        out  largest legal Q value, signed
//   best_action  out  action holding max_q (4'hF when no legal action)
//   no_legal     out  captured legal_mask was all zero
// ---------------------------------------------------------------------------
module q_max_finder #(
    parameter int Q_WIDTH   = 16,
    parameter int STATE_W   = 15,
    parameter int N_ACTIONS = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] state_idx,
    input  logic [N_ACTIONS-1:0] legal_mask,
    output logic               busy,
    output logic               done,
    output logic               q_rd_en,
    output logic [STATE_W-1:0] q_rd_state,
    output logic [3:0]         q_rd_action,
    input  logic [Q_WIDTH-1:0] q_rd_data,
    output logic [Q_WIDTH-1:0] max_q,
    output logic [3:0]         best_action,
    output logic               no_legal
);

    localparam logic [3:0] K_LAST      = 4'(N_ACTIONS - 1);
    localparam logic [3:0] ACTION_NONE = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Captured request
    logic [STATE_W-1:0]   state_r;
    logic [N_ACTIONS-1:0] mask_r;

    // Action counter, walks 0..N_ACTIONS-1 during SCAN, parked at 0 otherwise
    logic [3:0] k;

    // Read strobe/action delayed by the RAM latency so they line up with data
    logic       rd_vld_d;
    logic [3:0] rd_act_d;

    // Running maximum of the samples returned so far in this scan
    logic signed [Q_WIDTH-1:0] run_max;
    logic [3:0]                run_act;
    logic                      run_vld;

    // Next value of the running maximum, including this cycle's sample
    logic                      take_sample;
    logic signed [Q_WIDTH-1:0] upd_max;
    logic [3:0]                upd_act;

    // Result registers
    logic [Q_WIDTH-1:0] max_q_r;
    logic [3:0]         best_act_r;
    logic               no_legal_r;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and control outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        q_rd_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                busy    = 1'b1;
                q_rd_en = mask_r[k];
                if (k == K_LAST) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Compare: a returned sample replaces the running max when no max is held
    // yet or it is strictly greater (signed). Strict '>' keeps the lower
    // action on ties because actions arrive in ascending order.
    // -----------------------------------------------------------------------
    always_comb begin
        take_sample = rd_vld_d && (!run_vld || ($signed(q_rd_data) > run_max));
        upd_max     = run_max;
        upd_act     = run_act;
        if (take_sample) begin
            upd_max = $signed(q_rd_data);
            upd_act = rd_act_d;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= '0;
            mask_r     <= '0;
            k          <= '0;
            rd_vld_d   <= 1'b0;
            rd_act_d   <= '0;
            run_max    <= '0;
            run_act    <= '0;
            run_vld    <= 1'b0;
            max_q_r    <= '0;
            best_act_r <= '0;
            no_legal_r <= 1'b0;
        end else begin
            rd_vld_d <= q_rd_en;
            rd_act_d <= k;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_r <= state_idx;
                        mask_r  <= legal_mask;
                        k       <= '0;
                        run_vld <= 1'b0;
                    end
                end
                S_SCAN: begin
                    k <= (k == K_LAST) ? 4'd0 : k + 4'd1;
                    if (take_sample) begin
                        run_max <= upd_max;
                        run_act <= upd_act;
                        run_vld <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    // The last action's sample arrives in this cycle, so the
                    // results are loaded from the updated max, not run_max.
                    if (take_sample) begin
                        run_max <= upd_max;
                        run_act <= upd_act;
                        run_vld <= 1'b1;
                    end
                    if (mask_r == '0) begin
                        max_q_r    <= '0;
                        best_act_r <= ACTION_NONE;
                        no_legal_r <= 1'b1;
                    end else begin
                        max_q_r    <= upd_max;
                        best_act_r <= upd_act;
                        no_legal_r <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign q_rd_state  = state_r;
    assign q_rd_action = k;
    assign max_q       = max_q_r;
    assign best_action = best_act_r;
    assign no_legal    = no_legal_r;

endmodule

// File: tb/tb_q_max_finder.sv
// ---------------------------------------------------------------------------
// Testbench for q_max_finder. A behavioural Q-table row (q_row) answers the
// DUT's reads with one cycle of latency. Each scan pushes its expected
// result, computed from q_row and the mask, onto the scoreboard queues; the
// entry is popped and compared when done is observed.
// Cycle numbering: start is driven on a falling edge in cycle T and accepted
// on the following rising edge; the n-th falling edge after that lies in
// cycle T+n.
// ---------------------------------------------------------------------------
module tb_q_max_finder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [14:0] state_idx;
    logic [8:0]  legal_mask;
    logic        busy;
    logic        done;
    logic        q_rd_en;
    logic [14:0] q_rd_state;
    logic [3:0]  q_rd_action;
    logic [15:0] q_rd_data;
    logic [15:0] max_q;
    logic [3:0]  best_action;
    logic        no_legal;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Scoreboard
    logic [15:0] exp_max_q[$];
    logic [3:0]  exp_act_q[$];
    logic        exp_nl_q[$];

    // Q-table row served to the DUT, and the state it is expected to read
    logic [15:0] q_row [0:8];
    logic [14:0] exp_state;

    // Observations of the last monitored scan
    int          m_done_cyc;
    int          m_rd_cnt;
    int          m_first_rd;
    logic [8:0]  m_rd_seen;
    int          m_bad_rd;
    int          m_busy_cnt;
    logic [15:0] m_hold_max;
    logic [15:0] m_max;
    logic [3:0]  m_act;
    logic        m_nl;

    q_max_finder #(.Q_WIDTH(16), .STATE_W(15), .N_ACTIONS(9)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .state_idx   (state_idx),
        .legal_mask  (legal_mask),
        .busy        (busy),
        .done        (done),
        .q_rd_en     (q_rd_en),
        .q_rd_state  (q_rd_state),
        .q_rd_action (q_rd_action),
        .q_rd_data   (q_rd_data),
        .max_q       (max_q),
        .best_action (best_action),
        .no_legal    (no_legal)
    );

    // ---------------- clock / RAM model ----------------
    always #5 clk = ~clk;

    initial q_rd_data = 16'h0000;
    always @(posedge clk) begin
        if (q_rd_en) q_rd_data <= q_row[q_rd_action];
    end

    // ---------------- reference model ----------------
    function automatic void model(input logic [8:0] m, output logic [15:0] mx,
                                  output logic [3:0] ac, output logic nl);
        bit found;
        found = 1'b0;
        mx = 16'h0000;
        ac = 4'hF;
        nl = (m == 9'h000);
        for (int i = 0; i < 9; i++) begin
            if (m[i] && (!found || $signed(q_row[i]) > $signed(mx))) begin
                mx = q_row[i];
                ac = 4'(i);
                found = 1'b1;
            end
        end
        if (nl) begin
            mx = 16'h0000;
            ac = 4'hF;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_scan(input logic [14:0] s, input logic [8:0] m);
        logic [15:0] emx;
        logic [3:0]  eac;
        logic        enl;
        model(m, emx, eac, enl);
        exp_max_q.push_back(emx);
        exp_act_q.push_back(eac);
        exp_nl_q.push_back(enl);
        exp_state = s;
        @(negedge clk);
        start      = 1'b1;
        state_idx  = s;
        legal_mask = m;
    endtask

    // Follows one scan until done (bounded), optionally pulsing start with
    // junk request values at cycles inj1/inj2.
    task automatic run_monitor(input int inj1, input int inj2);
        m_done_cyc = -1;
        m_rd_cnt   = 0;
        m_first_rd = -1;
        m_rd_seen  = 9'h000;
        m_bad_rd   = 0;
        m_busy_cnt = 0;
        m_hold_max = 16'hxxxx;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == inj1 || n == inj2) begin
                start      = 1'b1;
                state_idx  = 15'($urandom);
                legal_mask = 9'($urandom);
            end else begin
                start = 1'b0;
            end
            if (n == 1) m_hold_max = max_q;
            if (busy) m_busy_cnt++;
            if (q_rd_en) begin
                m_rd_cnt++;
                if (m_first_rd < 0) m_first_rd = n;
                if (q_rd_action < 4'd9) m_rd_seen[q_rd_action] = 1'b1;
                if (q_rd_action != 4'(n - 1) || q_rd_state != exp_state) m_bad_rd++;
            end
            if (done) begin
                m_done_cyc = n;
                m_max = max_q;
                m_act = best_action;
                m_nl  = no_legal;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        state_idx = 15'h0;
        legal_mask = 9'h0;
        repeat (3) @(negedge clk);
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        chk_cnt++; if (q_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", q_rd_en); else pass_cnt++;
        chk_cnt++; if ({q_rd_state, q_rd_action} !== 19'h0) $display("FAIL reset_rd_addr: got %h/%h want 0/0", q_rd_state, q_rd_action); else pass_cnt++;
        chk_cnt++; if ({max_q, best_action, no_legal} !== 21'h0) $display("FAIL reset_results: got %h/%h/%b want 0/0/0", max_q, best_action, no_legal); else pass_cnt++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++; if ({busy, done, q_rd_en} !== 3'b000) $display("FAIL reset_idle: got %b want 000", {busy, done, q_rd_en}); else pass_cnt++;
    endtask

    task automatic test_single_cell();
        logic [15:0] e_max; logic [3:0] e_act; logic e_nl;
        for (int i = 0; i < 9; i++) q_row[i] = 16'h7000 + 16'(i);
        q_row[4] = 16'h0123;
        start_scan(15'h1234, 9'b000010000);
        run_monitor(-1, -1);
        chk_cnt++; if (m_done_cyc !== 11) $display("FAIL single_done_cyc: got %0d want 11", m_done_cyc); else pass_cnt++;
        chk_cnt++; if (m_rd_cnt !== 1 || m_first_rd !== 5) $display("FAIL single_rd: got cnt %0d at %0d want 1 at 5", m_rd_cnt, m_first_rd); else pass_cnt++;
        chk_cnt++; if (m_bad_rd !== 0) $display("FAIL single_rd_addr: got %0d bad want 0", m_bad_rd); else pass_cnt++;
        chk_cnt++; if (m_busy_cnt !== 11) $display("FAIL single_busy: got %0d want 11", m_busy_cnt); else pass_cnt++;
        e_max = exp_max_q.pop_front(); e_act = exp_act_q.pop_front(); e_nl = exp_nl_q.pop_front();
        chk_cnt++; if ({m_max, m_act, m_nl} !== {e_max, e_act, e_nl}) $display("FAIL single_result: got %h/%0d/%b want %h/%0d/%b", m_max, m_act, m_nl, e_max, e_act, e_nl); else pass_cnt++;
        chk_cnt++; if ({m_max, m_act} !== {16'h0123, 4'd4}) $display("FAIL single_const: got %h/%0d want 0123/4", m_max, m_act); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if ({done, busy} !== 2'b00) $display("FAIL single_after: got done/busy %b want 00", {done, busy}); else pass_cnt++;
        chk_cnt++; if ({max_q, best_action} !== {16'h0123, 4'd4}) $display("FAIL single_hold: got %h/%0d want 0123/4", max_q, best_action); else pass_cnt++;
    endtask

    task automatic test_full_board();
        logic [15:0] e_max; logic [3:0] e_act; logic e_nl;
        q_row[0] = 16'd10;  q_row[1] = -16'sd5; q_row[2] = 16'd300;
        q_row[3] = 16'd7;   q_row[4] = 16'd300; q_row[5] = 16'd0;
        q_row[6] = -16'sd1; q_row[7] = 16'd2;   q_row[8] = 16'd299;
        start_scan(15'h0042, 9'h1FF);
        run_monitor(-1, -1);
        chk_cnt++; if (m_done_cyc !== 11) $display("FAIL full_done_cyc: got %0d want 11", m_done_cyc); else pass_cnt++;
        chk_cnt++; if (m_rd_cnt !== 9 || m_rd_seen !== 9'h1FF || m_bad_rd !== 0) $display("FAIL full_rd: got cnt %0d seen %h bad %0d want 9/1ff/0", m_rd_cnt, m_rd_seen, m_bad_rd); else pass_cnt++;
        e_max = exp_max_q.pop_front(); e_act = exp_act_q.pop_front(); e_nl = exp_nl_q.pop_front();
        chk_cnt++; if ({m_max, m_act, m_nl} !== {e_max, e_act, e_nl}) $display("FAIL full_result: got %h/%0d/%b want %h/%0d/%b", m_max, m_act, m_nl, e_max, e_act, e_nl); else pass_cnt++;
        chk_cnt++; if ({m_max, m_act} !== {16'h012C, 4'd2}) $display("FAIL full_tie: got %h/%0d want 012c/2", m_max, m_act); else pass_cnt++;
    endtask

    task automatic test_all_negative();
        logic [15:0] e_max; logic [3:0] e_act; logic e_nl;
        q_row[0] = 16'h8000; q_row[1] = 16'h8001; q_row[2] = 16'h9000;
        q_row[3] = 16'hA000; q_row[4] = 16'hC000; q_row[5] = 16'hE000;
        q_row[6] = 16'hF000; q_row[7] = 16'hFFF0; q_row[8] = 16'h8000;
        start_scan(15'h7FFF, 9'h1FF);
        run_monitor(-1, -1);
        e_max = exp_max_q.pop_front(); e_act = exp_act_q.pop_front(); e_nl = exp_nl_q.pop_front();
        chk_cnt++; if (m_done_cyc !== 11) $display("FAIL neg_done_cyc: got %0d want 11", m_done_cyc); else pass_cnt++;
        chk_cnt++; if ({m_max, m_act, m_nl} !== {e_max, e_act, e_nl}) $display("FAIL neg_result: got %h/%0d/%b want %h/%0d/%b", m_max, m_act, m_nl, e_max, e_act, e_nl); else pass_cnt++;
        chk_cnt++; if ({m_max, m_act} !== {16'hFFF0, 4'd7}) $display("FAIL neg_signed: got %h/%0d want fff0/7", m_max, m_act); else pass_cnt++;
    endtask

    task automatic test_empty_mask();
        logic [15:0] e_max; logic [3:0] e_act; logic e_nl;
        for (int i = 0; i < 9; i++) q_row[i] = 16'h1111 * 16'(i + 1);
        start_scan(15'h0005, 9'h000);
        run_monitor(-1, -1);
        e_max = exp_max_q.pop_front(); e_act = exp_act_q.pop_front(); e_nl = exp_nl_q.pop_front();
        chk_cnt++; if (m_done_cyc !== 11) $display("FAIL empty_done_cyc: got %0d want 11", m_done_cyc); else pass_cnt++;
        chk_cnt++; if (m_rd_cnt !== 0) $display("FAIL empty_rd_cnt: got %0d want 0", m_rd_cnt); else pass_cnt++;
        chk_cnt++; if ({m_max, m_act, m_nl} !== {e_max, e_act, e_nl}) $display("FAIL empty_result: got %h/%h/%b want %h/%h/%b", m_max, m_act, m_nl, e_max, e_act, e_nl); else pass_cnt++;
        chk_cnt++; if ({m_max, m_act, m_nl} !== {16'h0000, 4'hF, 1'b1}) $display("FAIL empty_const: got %h/%h/%b want 0000/f/1", m_max, m_act, m_nl); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] e_max; logic [3:0] e_act; logic e_nl;
        logic [15:0] first_max;
        for (int i = 0; i < 9; i++) q_row[i] = 16'h0100 + 16'(i * 3);
        start_scan(15'h2AAA, 9'b011011011);
        run_monitor(4, 11);
        e_max = exp_max_q.pop_front(); e_act = exp_act_q.pop_front(); e_nl = exp_nl_q.pop_front();
        first_max = e_max;
        chk_cnt++; if (m_done_cyc !== 11) $display("FAIL b2b_first_done: got %0d want 11", m_done_cyc); else pass_cnt++;
        chk_cnt++; if (m_bad_rd !== 0 || m_rd_seen !== 9'b011011011) $display("FAIL b2b_first_rd: got bad %0d seen %h want 0/0db", m_bad_rd, m_rd_seen); else pass_cnt++;
        chk_cnt++; if ({m_max, m_act, m_nl} !== {e_max, e_act, e_nl}) $display("FAIL b2b_first_result: got %h/%0d/%b want %h/%0d/%b", m_max, m_act, m_nl, e_max, e_act, e_nl); else pass_cnt++;
        // New row for the second scan, accepted in cycle T+12
        for (int i = 0; i < 9; i++) q_row[i] = 16'h0500 - 16'(i * 5);
        start_scan(15'h1555, 9'b110000100);
        run_monitor(-1, -1);
        e_max = exp_max_q.pop_front(); e_act = exp_act_q.pop_front(); e_nl = exp_nl_q.pop_front();
        chk_cnt++; if (m_hold_max !== first_max) $display("FAIL b2b_hold: got %h want %h", m_hold_max, first_max); else pass_cnt++;
        chk_cnt++; if (m_done_cyc !== 11 || m_bad_rd !== 0) $display("FAIL b2b_second_done: got cyc %0d bad %0d want 11/0", m_done_cyc, m_bad_rd); else pass_cnt++;
        chk_cnt++; if ({m_max, m_act, m_nl} !== {e_max, e_act, e_nl}) $display("FAIL b2b_second_result: got %h/%0d/%b want %h/%0d/%b", m_max, m_act, m_nl, e_max, e_act, e_nl); else pass_cnt++;
    endtask

    task automatic test_reset_mid_scan();
        logic [15:0] e_max; logic [3:0] e_act; logic e_nl;
        int done_seen;
        for (int i = 0; i < 9; i++) q_row[i] = 16'h2000 + 16'(i);
        start_scan(15'h0333, 9'h1FF);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        // The abandoned scan never produces a result
        void'(exp_max_q.pop_back()); void'(exp_act_q.pop_back()); void'(exp_nl_q.pop_back());
        chk_cnt++; if ({busy, done, q_rd_en} !== 3'b000) $display("FAIL rstmid_ctrl: got %b want 000", {busy, done, q_rd_en}); else pass_cnt++;
        chk_cnt++; if ({q_rd_state, q_rd_action} !== 19'h0) $display("FAIL rstmid_addr: got %h/%h want 0/0", q_rd_state, q_rd_action); else pass_cnt++;
        chk_cnt++; if ({max_q, best_action, no_legal} !== 21'h0) $display("FAIL rstmid_results: got %h/%h/%b want 0/0/0", max_q, best_action, no_legal); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        chk_cnt++; if (done_seen !== 0) $display("FAIL rstmid_no_done: got %0d active cycles want 0", done_seen); else pass_cnt++;
        start_scan(15'h0444, 9'b101010101);
        run_monitor(-1, -1);
        e_max = exp_max_q.pop_front(); e_act = exp_act_q.pop_front(); e_nl = exp_nl_q.pop_front();
        chk_cnt++; if (m_done_cyc !== 11 || m_rd_cnt !== 5) $display("FAIL rstmid_fresh: got cyc %0d rd %0d want 11/5", m_done_cyc, m_rd_cnt); else pass_cnt++;
        chk_cnt++; if ({m_max, m_act, m_nl} !== {e_max, e_act, e_nl}) $display("FAIL rstmid_fresh_result: got %h/%0d/%b want %h/%0d/%b", m_max, m_act, m_nl, e_max, e_act, e_nl); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [15:0] e_max; logic [3:0] e_act; logic e_nl;
        logic [15:0] pick [0:3];
        logic [8:0]  m;
        pick[0] = 16'h7FFF; pick[1] = 16'h8000; pick[2] = 16'h0000; pick[3] = 16'hFFFF;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 9; i++) begin
                if (t < 3) q_row[i] = pick[$urandom_range(0, 3)];
                else       q_row[i] = 16'($urandom);
            end
            m = 9'($urandom_range(0, 511));
            start_scan(15'($urandom), m);
            run_monitor(-1, -1);
            e_max = exp_max_q.pop_front(); e_act = exp_act_q.pop_front(); e_nl = exp_nl_q.pop_front();
            chk_cnt++; if (m_done_cyc !== 11 || m_bad_rd !== 0 || m_rd_seen !== m) $display("FAIL rand%0d_timing: got cyc %0d bad %0d seen %h want 11/0/%h", t, m_done_cyc, m_bad_rd, m_rd_seen, m); else pass_cnt++;
            chk_cnt++; if ({m_max, m_act, m_nl} !== {e_max, e_act, e_nl}) $display("FAIL rand%0d_result: got %h/%h/%b want %h/%h/%b", t, m_max, m_act, m_nl, e_max, e_act, e_nl); else pass_cnt++;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_cell();
        test_full_board();
        test_all_negative();
        test_empty_mask();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        chk_cnt++;
        $display("FAIL watchdog: got timeout want completion");
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
